beta_timer_mmio: RTL and testbench

Memory-mapped timer and interrupt source on the data-memory side of the beta processor. It decodes the CPU data port (`memAddr`, `memWriteData`, `MemRead`, `MemWrite`) and returns read data combinationally, so the single-cycle datapath never stalls. It runs a prescaled down-counter and drives the CPU's `irq` input. Writes use the same cycle as the store instruction and take effect at the next clock edge.

---
 rtl/beta_pkg.sv | 17 +
 rtl/beta_tick_gen.sv | 31 +++
 rtl/beta_timer_mmio.sv | 113 +++++++++++
 tb/tb_beta_timer_mmio.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared constants for the beta memory-mapped peripherals: timer register
// indices (memAddr[4:2]) and bit positions within CTRL and STATUS.
package beta_pkg;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_LOAD     = 3'd1;
    localparam logic [2:0] TMR_COUNT    = 3'd2;
    localparam logic [2:0] TMR_STATUS   = 3'd3;
    localparam logic [2:0] TMR_PRESCALE = 3'd4;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_IE = 1;
    localparam int unsigned CTRL_AR = 2;

    localparam int unsigned STATUS_PEND = 0;

endpackage

// File: rtl/beta_tick_gen.sv
// Prescaler for the beta timer: one-cycle tick every presc+1 enabled cycles.
// clr restarts the phase so a shrinking prescale can never be overrun.
module beta_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] presc,
    input  logic        clr,
    output logic        tick
);

    logic [31:0] pscnt_q;
    logic [31:0] pscnt_d;

    always_comb begin
        tick    = en && (pscnt_q == presc);
        pscnt_d = pscnt_q + 32'd1;
        if (!en || clr || tick) begin
            pscnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pscnt_q <= '0;
        end else begin
            pscnt_q <= pscnt_d;
        end
    end

endmodule

// File: rtl/beta_timer_mmio.sv
// Memory-mapped prescaled down-counter with level interrupt for the beta CPU
// data port. Reads are combinational; writes land on the next rising edge.
module beta_timer_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] memReadData,
    output logic        hit,
    output logic        irq
);
    import beta_pkg::*;

    logic [2:0]  ctrl_q,  ctrl_d;
    logic [31:0] load_q,  load_d;
    logic [31:0] count_q, count_d;
    logic        pend_q,  pend_d;
    logic [31:0] presc_q, presc_d;

    logic [2:0]  idx;
    logic        wr;
    logic        tick;
    logic        expire;
    logic        presc_wr;
    logic        unused_addr_bits;

    assign hit              = (memAddr[31:5] == BASE_ADDR[31:5]);
    assign idx              = memAddr[4:2];
    assign wr               = hit && MemWrite;
    assign presc_wr         = wr && (idx == TMR_PRESCALE);
    assign expire           = tick && (count_q == '0);
    assign irq              = pend_q && ctrl_q[CTRL_IE];
    assign unused_addr_bits = ^memAddr[1:0];

    beta_tick_gen u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_q[CTRL_EN]),
        .presc (presc_q),
        .clr   (presc_wr),
        .tick  (tick)
    );

    // Timer events are applied first and bus writes override them, except
    // PEND where a same-edge expiry beats the write-1-clear.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
        presc_d = presc_q;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[CTRL_AR]) begin
                count_d = load_q;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        if (wr) begin
            case (idx)
                TMR_CTRL:     ctrl_d  = memWriteData[2:0];
                TMR_LOAD:     load_d  = memWriteData;
                TMR_COUNT:    count_d = memWriteData;
                TMR_STATUS:   if (memWriteData[STATUS_PEND]) pend_d = 1'b0;
                TMR_PRESCALE: presc_d = memWriteData;
                default:      ;
            endcase
        end

        if (expire) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        memReadData = '0;
        if (hit && MemRead) begin
            case (idx)
                TMR_CTRL:     memReadData = {29'd0, ctrl_q};
                TMR_LOAD:     memReadData = load_q;
                TMR_COUNT:    memReadData = count_q;
                TMR_STATUS:   memReadData = {31'd0, pend_q};
                TMR_PRESCALE: memReadData = presc_q;
                default:      memReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_beta_timer_mmio.sv
// Directed self-checking bench for beta_timer_mmio: register/decode vector
// table followed by hand-timed one-shot, auto-reload, collision and reset runs.
module tb_beta_timer_mmio;

    localparam logic [31:0] B = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] memReadData;
    logic        hit;
    logic        irq;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    beta_timer_mmio #(.BASE_ADDR(B)) dut (
        .clk          (clk),
        .reset        (reset),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .memReadData  (memReadData),
        .hit          (hit),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        do_wr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] rd_addr;
        logic [31:0] exp_data;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        memAddr      = addr;
        memWriteData = data;
        MemWrite     = 1'b1;
        @(posedge clk);
        #1;
        MemWrite     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic h);
        memAddr = addr;
        MemRead = 1'b1;
        #1;
        data    = memReadData;
        h       = hit;
        MemRead = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        rd(addr, d, h);
        check(name, d, exp);
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        h;

        reset        = 1'b1;
        memAddr      = '0;
        memWriteData = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(1);

        check("reset_irq", {31'd0, irq}, 32'd0);
        chk_rd("reset_ctrl",  B + 32'h00, 32'd0);
        chk_rd("reset_load",  B + 32'h04, 32'd0);
        chk_rd("reset_count", B + 32'h08, 32'd0);
        chk_rd("reset_stat",  B + 32'h0C, 32'd0);
        chk_rd("reset_presc", B + 32'h10, 32'd0);

        // EN stays 0 throughout the table so no counting interferes
        vecs.push_back('{"ctrl_rw",      1'b1, B + 32'h00, 32'hFFFF_FFFA, B + 32'h00, 32'h0000_0002, 1'b1});
        vecs.push_back('{"load_rw",      1'b1, B + 32'h04, 32'hDEAD_BEEF, B + 32'h04, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{"count_rw",     1'b1, B + 32'h08, 32'h0000_1234, B + 32'h08, 32'h0000_1234, 1'b1});
        vecs.push_back('{"presc_rw",     1'b1, B + 32'h10, 32'h0000_0005, B + 32'h10, 32'h0000_0005, 1'b1});
        vecs.push_back('{"status_w1c0",  1'b1, B + 32'h0C, 32'hFFFF_FFFF, B + 32'h0C, 32'h0000_0000, 1'b1});
        vecs.push_back('{"idx5_rd0",     1'b1, B + 32'h14, 32'hFFFF_FFFF, B + 32'h14, 32'h0000_0000, 1'b1});
        vecs.push_back('{"idx7_rd0",     1'b1, B + 32'h18, 32'hFFFF_FFFF, B + 32'h1C, 32'h0000_0000, 1'b1});
        vecs.push_back('{"outside_hi",   1'b1, B + 32'h20, 32'h0000_0007, B + 32'h20, 32'h0000_0000, 1'b0});
        vecs.push_back('{"ctrl_kept",    1'b0, B,          32'h0,         B + 32'h00, 32'h0000_0002, 1'b1});
        vecs.push_back('{"load_kept",    1'b0, B,          32'h0,         B + 32'h04, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{"lowbits_ign",  1'b1, B + 32'h07, 32'h0000_0055, B + 32'h05, 32'h0000_0055, 1'b1});
        vecs.push_back('{"outside_lo",   1'b1, B - 32'h04, 32'h0000_0077, B + 32'h04, 32'h0000_0055, 1'b1});
        vecs.push_back('{"outside_lo_r", 1'b0, B,          32'h0,         B - 32'h1C, 32'h0000_0000, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].wr_addr, vecs[i].wr_data);
            rd(vecs[i].rd_addr, d, h);
            check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
            check({vecs[i].name, "_hit"}, {31'd0, h}, {31'd0, vecs[i].exp_hit});
        end

        // One-shot: COUNT=3, PRESCALE=0 -> PEND on the 4th edge after CTRL write
        wr(B + 32'h04, 32'd3);
        wr(B + 32'h08, 32'd3);
        wr(B + 32'h10, 32'd0);
        wr(B + 32'h00, 32'd3);
        for (int unsigned i = 1; i <= 4; i++) begin
            cycles(1);
            chk_rd($sformatf("oneshot_pend_e%0d", i), B + 32'h0C, (i == 4) ? 32'd1 : 32'd0);
            check($sformatf("oneshot_irq_e%0d", i), {31'd0, irq}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk_rd("oneshot_en_clr", B + 32'h00, 32'd2);
        chk_rd("oneshot_cnt0",   B + 32'h08, 32'd0);
        cycles(2);
        chk_rd("oneshot_cnt_hold", B + 32'h08, 32'd0);

        // Masking: PEND=1, IE=0
        wr(B + 32'h00, 32'd0);
        check("mask_irq0", {31'd0, irq}, 32'd0);
        chk_rd("mask_pend1", B + 32'h0C, 32'd1);
        memAddr      = B;
        memWriteData = 32'd2;
        MemWrite     = 1'b1;
        #1;
        check("mask_irq_pre_edge", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        check("mask_irq_set", {31'd0, irq}, 32'd1);
        wr(B + 32'h0C, 32'd1);
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);

        // Auto-reload: COUNT=LOAD=2, PRESCALE=1 -> PEND every 6 cycles
        wr(B + 32'h08, 32'd2);
        wr(B + 32'h04, 32'd2);
        wr(B + 32'h10, 32'd1);
        wr(B + 32'h00, 32'd7);
        cycles(5);
        chk_rd("ar_pend_e5", B + 32'h0C, 32'd0);
        cycles(1);
        chk_rd("ar_pend_e6", B + 32'h0C, 32'd1);
        check("ar_irq_e6", {31'd0, irq}, 32'd1);
        wr(B + 32'h0C, 32'd1);
        chk_rd("ar_clr_e7", B + 32'h0C, 32'd0);
        check("ar_irq_e7", {31'd0, irq}, 32'd0);
        cycles(4);
        chk_rd("ar_pend_e11", B + 32'h0C, 32'd0);
        cycles(1);
        chk_rd("ar_pend_e12", B + 32'h0C, 32'd1);
        chk_rd("ar_reload_e12", B + 32'h08, 32'd2);

        // STATUS clear landing on expiry edge E18: set wins
        cycles(5);
        wr(B + 32'h0C, 32'd1);
        chk_rd("coll_pend_stays", B + 32'h0C, 32'd1);
        chk_rd("coll_reload_e18", B + 32'h08, 32'd2);

        // COUNT write landing on tick edge E20: written value wins
        cycles(1);
        wr(B + 32'h08, 32'd9);
        chk_rd("coll_count9", B + 32'h08, 32'd9);
        cycles(1);
        chk_rd("coll_count9_e21", B + 32'h08, 32'd9);
        cycles(1);
        chk_rd("coll_count8_e22", B + 32'h08, 32'd8);

        // Asynchronous reset mid-cycle with PEND=1, IE=1
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_irq0", {31'd0, irq}, 32'd0);
        chk_rd("async_ctrl",  B + 32'h00, 32'd0);
        chk_rd("async_count", B + 32'h08, 32'd0);
        chk_rd("async_stat",  B + 32'h0C, 32'd0);
        chk_rd("async_presc", B + 32'h10, 32'd0);
        chk_rd("async_load",  B + 32'h04, 32'd0);
        reset = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
